// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM sequencer for an RV32I datapath: decodes instrCode into
// datapath controls and runs the load/store bus handshake with a timeout.
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        PCEn,
  output logic        regFileWe,
  output logic        ALUSrcMuxSel,
  output logic [3:0]  ALUControl,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busEn,
  output logic        busWe,
  output logic        illegalInstr,
  output logic        busFault
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_illegal, r_fault;
  logic          w_set_illegal, w_set_fault;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_unused;
  assign w_opcode = instrCode[6:0];
  assign w_funct3 = instrCode[14:12];
  assign w_unused = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  logic       w_known, w_mem_op, w_is_store, w_we_exe;
  logic       w_src, w_br, w_jal, w_jalr;
  logic [3:0] w_alu;
  logic [2:0] w_rfwd;

  // Pure opcode decode; held stable by the datapath across the whole instruction.
  always_comb begin
    w_known    = 1'b1;
    w_mem_op   = 1'b0;
    w_is_store = 1'b0;
    w_we_exe   = 1'b0;
    w_src      = 1'b0;
    w_br       = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_alu      = 4'b0000;
    w_rfwd     = 3'b000;
    case (w_opcode)
      OP_R:  begin w_alu = {instrCode[30], w_funct3}; w_we_exe = 1'b1; end
      OP_I:  begin
        w_alu    = {instrCode[30] & (w_funct3 == 3'b101), w_funct3};
        w_src    = 1'b1;
        w_we_exe = 1'b1;
      end
      OP_L:  begin w_src = 1'b1; w_mem_op = 1'b1; w_rfwd = 3'b001; end
      OP_S:  begin w_src = 1'b1; w_mem_op = 1'b1; w_is_store = 1'b1; end
      OP_B:  begin w_alu = {1'b0, w_funct3}; w_br = 1'b1; end
      OP_LU: begin w_rfwd = 3'b010; w_we_exe = 1'b1; end
      OP_AU: begin w_rfwd = 3'b011; w_we_exe = 1'b1; end
      OP_J:  begin w_rfwd = 3'b100; w_we_exe = 1'b1; w_jal = 1'b1; end
      OP_JL: begin w_rfwd = 3'b100; w_we_exe = 1'b1; w_jal = 1'b1; w_jalr = 1'b1; end
      default: w_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_illegal <= r_illegal | w_set_illegal;
      r_fault   <= r_fault | w_set_fault;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = '0;
    w_set_illegal = 1'b0;
    w_set_fault   = 1'b0;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: begin
        if (w_known) begin
          w_state_next = S_EXE;
        end else begin
          w_state_next  = S_TRAP;
          w_set_illegal = 1'b1;
        end
      end
      S_EXE:    w_state_next = w_mem_op ? S_MEM : S_FETCH;
      S_MEM: begin
        if (busReady) begin
          w_state_next = w_is_store ? S_FETCH : S_WB;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
          w_state_next = S_TRAP;
          w_set_fault  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_WB:     w_state_next = S_FETCH;
      S_TRAP:   w_state_next = S_TRAP;
      default:  w_state_next = S_FETCH;
    endcase
  end

  logic w_live;
  assign w_live = (r_state != S_TRAP);

  assign PCEn          = (r_state == S_FETCH) & ~reset;
  assign regFileWe     = ((r_state == S_EXE) & w_we_exe) | (r_state == S_WB);
  assign busEn         = (r_state == S_MEM);
  assign busWe         = (r_state == S_MEM) & w_is_store;
  assign ALUSrcMuxSel  = w_live & w_src;
  assign ALUControl    = w_live ? w_alu : 4'b0000;
  assign RFWDSrcMuxSel = w_live ? w_rfwd : 3'b000;
  assign branch        = w_live & w_br;
  assign jal           = w_live & w_jal;
  assign jalr          = w_live & w_jalr;
  assign illegalInstr  = r_illegal;
  assign busFault      = r_fault;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Multi-cycle sequencer for the RV32I datapath.
- Decodes the current `instrCode` and drives every datapath control input: `PCEn`, `regFileWe`, `ALUSrcMuxSel`, `ALUControl`, `RFWDSrcMuxSel`, `branch`, `jal`, `jalr`.
- Runs the data-bus handshake for loads and stores, with a bus timeout.
- Sits beside the datapath inside the CPU top. Instruction memory is combinational on `instrMemAddr`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: maximum MEM-state cycles to wait for `busReady`; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `instrCode` in 32: instruction at the current PC.
- `busReady` in 1: bus slave completion; sampled only in MEM.
- `PCEn` out 1: PC load enable.
- `regFileWe` out 1: register-file write enable.
- `ALUSrcMuxSel` out 1: 0 selects the rs2 value, 1 selects the immediate.
- `ALUControl` out 4: ALU operation; bits [2:0] also serve as the branch condition.
- `RFWDSrcMuxSel` out 3: writeback source. 000 ALU, 001 load data, 010 imm, 011 PC+imm, 100 PC+4.
- `branch`, `jal`, `jalr` out 1 each: PC source controls.
- `busEn` out 1: bus access request.
- `busWe` out 1: bus write (store).
- `illegalInstr` out 1: sticky flag, unknown opcode.
- `busFault` out 1: sticky flag, bus timeout.

## Operation
- States: FETCH, DECODE, EXE, MEM, WB, TRAP.
- Transitions:
  - FETCH → DECODE.
  - DECODE → EXE. If the opcode is unknown, DECODE → TRAP and `illegalInstr` is set.
  - EXE → MEM for L/S. EXE → FETCH for all other opcodes.
  - MEM → WB (load) or MEM → FETCH (store) in the cycle after `busReady` is sampled high.
  - MEM → TRAP with `busFault` set when `TIMEOUT_CYCLES` MEM cycles pass without `busReady`.
  - WB → FETCH.
  - TRAP is left only by reset.
- Opcodes: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, LU 0110111, AU 0010111, J 1101111, JL 1100111.
- Decoded signals are combinational from `instrCode` in every non-TRAP state. They therefore stay constant from DECODE through the instruction's last state; the datapath pipeline registers depend on this.
- `ALUControl` by opcode:
  - R: `{instr[30], instr[14:12]}`.
  - I: `{instr[30] & (funct3==101), funct3}`.
  - L, S, AU, LU, J, JL: 0000 (ADD).
  - B: `{1'b0, funct3}`.
- Encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- `ALUSrcMuxSel` = 1 for I, L, S; 0 otherwise.
- `RFWDSrcMuxSel` by opcode: R and I → 000; L → 001; LU → 010; AU → 011; J and JL → 100; others → 000.
- PC source controls:
  - `branch` = 1 for B only.
  - `jal` = 1 for J and JL.
  - `jalr` = 1 for JL only.
- Strobes:
  - `PCEn` = 1 in FETCH only. The PC then loads the PC-select value registered at the end of the previous EXE (0 after reset).
  - `regFileWe` = 1 in EXE for R, I, LU, AU, J, JL, and in WB for L.
  - `regFileWe` = 0 for B and S.
  - `busEn` = 1 throughout MEM.
  - `busWe` = 1 throughout MEM for stores only.
- Timeout counter:
  - Cleared on MEM entry; increments each MEM cycle with `busReady` low.
  - Reaching `TIMEOUT_CYCLES`-1 with `busReady` low → TRAP.
  - `busReady` high on that same cycle wins: normal completion.
- TRAP: all strobes 0, decoded outputs forced 0, flags held.

## Timing
- Reset values, and values while `reset` is high:
  - state = FETCH.
  - `PCEn`, `regFileWe`, `busEn`, `busWe`, `illegalInstr`, `busFault` = 0.
  - Counter = 0.
  - `PCEn` is gated low during reset.
- Latency: B, R, I, LU, AU, J, JL take 3 cycles; S takes 3 + k cycles; L takes 4 + k cycles, where k ≥ 1 is the number of MEM cycles.
- Bus handshake:
  - `busEn`/`busWe` rise on MEM entry and are held until the cycle `busReady` is sampled high.
  - They drop on the next edge.
  - `busReady` outside MEM is ignored.
- Loads: load data is registered by the datapath on the `busReady` cycle and written in WB.
- Reset asserted mid-instruction (any state, including MEM with `busEn` high): outputs drop immediately and execution restarts at FETCH.
- First `PCEn` after reset release occurs in the first cycle; the first instruction decoded is at address 0.

## Test plan
- Reset release with `instrCode`=0x00500093 (addi x1,x0,5) → `PCEn`=1 in cycle 0. In cycle 2: `regFileWe`=1, `ALUSrcMuxSel`=1, `ALUControl`=0000, `RFWDSrcMuxSel`=000. Then FETCH again.
- R-type sub, 0x40208133 → `ALUControl`=1000, `ALUSrcMuxSel`=0, write in EXE. srai, 0x4010D093 → `ALUControl`=1101.
- Load, 0x0000A103, with `busReady` held low 2 cycles → `busEn`=1 for 3 MEM cycles, `busWe`=0. Next, WB with `regFileWe`=1, `RFWDSrcMuxSel`=001. Total 7 cycles.
- Store, 0x0020A023, with `busReady` high immediately → one MEM cycle with `busEn`=`busWe`=1. `regFileWe` never asserts. Next cycle FETCH.
- jalr, 0x000080E7 → `jal`=1, `jalr`=1, `RFWDSrcMuxSel`=100, write in EXE. beq, 0x00208463 → `branch`=1, `ALUControl`=0000, no write.
- Fault cases:
  - Opcode 0x7F → TRAP with `illegalInstr`=1.
  - A store with `busReady` never high and `TIMEOUT_CYCLES`=4 → TRAP after 4 MEM cycles with `busFault`=1.
  - Both flags clear and FETCH resumes only on `reset`.
